// File: rtl/fetch_sequencer.sv
`timescale 1ns/1ps
// Instruction-fetch controller: owns the PC, fetches one word per cycle into a
// 2-entry output buffer, and handles redirects and a sticky misalignment fault.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter int          DEPTH_WORDS = 128
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic [31:0] Address,
    input  logic [31:0] Instruction,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutInstr,
    output logic [31:0] OutPC,
    output logic [31:0] OutPCPlus4,
    output logic        Fault,
    output logic [1:0]  State
);

    // Handshake: the head entry moves to the consumer on any rising edge where
    // OutValid && OutReady; OutValid never depends combinationally on OutReady.
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HALT = 2'd2} state_t;

    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    function automatic logic [31:0] wrap(input logic [31:0] a);
        return a % SPAN;
    endfunction

    state_t      state;
    logic [31:0] pc;
    logic [1:0]  count;
    logic [31:0] tail_instr;
    logic [31:0] tail_pc;
    logic        do_pop;
    logic        do_push;
    logic        misaligned;
    logic [1:0]  count_next;

    assign Address    = pc;
    assign State      = state;
    assign do_pop     = OutValid && OutReady;
    assign misaligned = RedirectTarget[1:0] != 2'b00;
    assign do_push    = (state == FETCH) && Run && !Redirect && ((count != 2'd2) || do_pop);

    always_comb begin
        count_next = count + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            count      <= 2'd0;
            OutValid   <= 1'b0;
            OutInstr   <= 32'd0;
            OutPC      <= 32'd0;
            OutPCPlus4 <= 32'd4;
            tail_instr <= 32'd0;
            tail_pc    <= 32'd0;
            Fault      <= 1'b0;
        end else if (state != HALT && Redirect) begin
            // Redirect flushes the buffer and wins over any fetch or pop.
            count    <= 2'd0;
            OutValid <= 1'b0;
            if (misaligned) begin
                Fault <= 1'b1;
                state <= HALT;
            end else begin
                pc    <= wrap(RedirectTarget);
                state <= Run ? FETCH : IDLE;
            end
        end else begin
            case (state)
                IDLE:    if (Run) state <= FETCH;
                FETCH:   if (!Run) state <= IDLE;
                default: state <= state;
            endcase

            if (do_push) pc <= wrap(pc + 32'd4);

            // The new word lands in the head when the head is (or becomes) free.
            if (do_push && (count == 2'd0 || (count == 2'd1 && do_pop))) begin
                OutInstr   <= Instruction;
                OutPC      <= pc;
                OutPCPlus4 <= wrap(pc + 32'd4);
            end else if (do_pop && count == 2'd2) begin
                OutInstr   <= tail_instr;
                OutPC      <= tail_pc;
                OutPCPlus4 <= wrap(tail_pc + 32'd4);
            end

            if (do_push && ((count == 2'd1 && !do_pop) || count == 2'd2)) begin
                tail_instr <= Instruction;
                tail_pc    <= pc;
            end

            count    <= count_next;
            OutValid <= count_next != 2'd0;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
// Directed bench for fetch_sequencer with memory image mem[i] = 3*i; expected
// head entries are queued by the driver and checked by an output monitor.
module tb_fetch_sequencer;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HALT  = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] address;
    logic [31:0] instruction;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        fault;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;
    logic [95:0] exp_q[$];

    always #5 clk = ~clk;

    assign instruction = 32'(address[8:2]) * 32'd3;

    fetch_sequencer #(.RESET_PC(32'd0), .DEPTH_WORDS(128)) dut (
        .Clk(clk),
        .Reset(rst),
        .Run(run),
        .Redirect(redirect),
        .RedirectTarget(target),
        .Address(address),
        .Instruction(instruction),
        .OutValid(out_valid),
        .OutReady(out_ready),
        .OutInstr(out_instr),
        .OutPC(out_pc),
        .OutPCPlus4(out_pc_plus4),
        .Fault(fault),
        .State(state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        run       = 1'b0;
        redirect  = 1'b0;
        target    = 32'd0;
        out_ready = 1'b0;
        step(1);
        rst = 1'b0;
    endtask

    task automatic expect_entry(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [31:0] pcp4);
        exp_q.push_back({instr, pc, pcp4});
    endtask

    // Monitor: compares every accepted head entry against the queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output instr=%0d pc=%0d expected=none", out_instr, out_pc);
            end else begin
                logic [95:0] e;
                e = exp_q.pop_front();
                check("mon_instr", out_instr, e[95:64]);
                check("mon_pc", out_pc, e[63:32]);
                check("mon_pc_plus4", out_pc_plus4, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_address", address, 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_pc_plus4", out_pc_plus4, 32'd4);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_state", 32'(state), 32'(ST_IDLE));

        // Streaming
        expect_entry(32'd0, 32'd0, 32'd4);
        expect_entry(32'd3, 32'd4, 32'd8);
        expect_entry(32'd6, 32'd8, 32'd12);
        expect_entry(32'd9, 32'd12, 32'd16);
        run = 1'b1;
        out_ready = 1'b1;
        step(1);
        check("stream_first_fetch_valid", 32'(out_valid), 32'd0);
        step(1);
        check("stream_valid_rise", 32'(out_valid), 32'd1);
        check("stream_first_instr", out_instr, 32'd0);
        step(3);
        run = 1'b0;
        step(1);
        check("stream_drained_valid", 32'(out_valid), 32'd0);
        check("stream_hold_address", address, 32'd16);
        check("stream_idle", 32'(state), 32'(ST_IDLE));

        // Backpressure
        do_reset();
        run = 1'b1;
        step(3);
        check("bp_address_full", address, 32'd8);
        check("bp_instr_full", out_instr, 32'd0);
        step(2);
        check("bp_address_hold", address, 32'd8);
        check("bp_valid_hold", 32'(out_valid), 32'd1);
        check("bp_instr_stable", out_instr, 32'd0);
        check("bp_pc_stable", out_pc, 32'd0);
        expect_entry(32'd0, 32'd0, 32'd4);
        expect_entry(32'd3, 32'd4, 32'd8);
        expect_entry(32'd6, 32'd8, 32'd12);
        expect_entry(32'd9, 32'd12, 32'd16);
        expect_entry(32'd12, 32'd16, 32'd20);
        out_ready = 1'b1;
        step(3);
        run = 1'b0;
        step(2);
        check("bp_drained_valid", 32'(out_valid), 32'd0);
        check("bp_final_address", address, 32'd20);

        // Redirect with a full buffer
        do_reset();
        run = 1'b1;
        step(3);
        check("redir_full_valid", 32'(out_valid), 32'd1);
        redirect = 1'b1;
        target = 32'd40;
        step(1);
        check("redir_flush_valid", 32'(out_valid), 32'd0);
        check("redir_address", address, 32'd40);
        redirect = 1'b0;
        out_ready = 1'b1;
        expect_entry(32'd30, 32'd40, 32'd44);
        step(1);
        check("redir_instr", out_instr, 32'd30);
        check("redir_pc", out_pc, 32'd40);
        check("redir_pc_plus4", out_pc_plus4, 32'd44);
        run = 1'b0;
        step(1);
        check("redir_drained_valid", 32'(out_valid), 32'd0);
        check("redir_final_address", address, 32'd44);

        // Wrap at the top of memory
        do_reset();
        run = 1'b1;
        out_ready = 1'b1;
        redirect = 1'b1;
        target = 32'd508;
        expect_entry(32'd381, 32'd508, 32'd0);
        expect_entry(32'd0, 32'd0, 32'd4);
        step(1);
        check("wrap_address", address, 32'd508);
        redirect = 1'b0;
        step(1);
        check("wrap_instr", out_instr, 32'd381);
        check("wrap_pc_plus4", out_pc_plus4, 32'd0);
        check("wrap_next_address", address, 32'd0);
        step(1);
        run = 1'b0;
        step(1);
        check("wrap_drained_valid", 32'(out_valid), 32'd0);
        check("wrap_final_address", address, 32'd4);

        // Misaligned redirect and sticky fault
        do_reset();
        run = 1'b1;
        step(3);
        redirect = 1'b1;
        target = 32'd42;
        step(1);
        check("fault_set", 32'(fault), 32'd1);
        check("fault_valid", 32'(out_valid), 32'd0);
        check("fault_address", address, 32'd8);
        check("fault_state", 32'(state), 32'(ST_HALT));
        target = 32'd40;
        out_ready = 1'b1;
        step(3);
        check("halt_fault_sticky", 32'(fault), 32'd1);
        check("halt_address", address, 32'd8);
        check("halt_valid", 32'(out_valid), 32'd0);
        check("halt_state", 32'(state), 32'(ST_HALT));
        do_reset();
        check("fault_cleared", 32'(fault), 32'd0);
        check("fault_reset_state", 32'(state), 32'(ST_IDLE));
        check("fault_reset_address", address, 32'd0);

        // Reset mid-stream with two entries buffered
        run = 1'b1;
        step(3);
        check("midrst_full_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        redirect = 1'b1;
        target = 32'd40;
        step(1);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_address", address, 32'd0);
        check("midrst_state", 32'(state), 32'(ST_IDLE));
        rst = 1'b0;
        redirect = 1'b0;
        run = 1'b1;
        out_ready = 1'b1;
        expect_entry(32'd0, 32'd0, 32'd4);
        expect_entry(32'd3, 32'd4, 32'd8);
        step(3);
        run = 1'b0;
        step(1);
        check("midrst_drained_valid", 32'(out_valid), 32'd0);
        check("midrst_final_address", address, 32'd8);

        step(2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
